// File: rtl/key_event_filter.sv
// Debounces an 8-bit raw key code into a held level plus a one-cycle press event.
// Defining KEY_EVENT_FILTER_REPEAT_EN adds auto-repeat of held keys (except pause/menu).
module key_event_filter #(
    parameter int unsigned STABLE_CYCLES = 16,
    parameter int unsigned REPEAT_CYCLES = 4096
) (
    input  logic       Clk,
    input  logic       Reset,
    input  logic [7:0] keycode_raw,
    output logic [7:0] key_level,
    output logic       key_evt,
    output logic [7:0] key_evt_code
);

    localparam int unsigned      CNT_W   = $clog2(STABLE_CYCLES);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STABLE_CYCLES - 1);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_QUAL = 2'd1;
    localparam logic [1:0] S_HELD = 2'd2;
    localparam logic [1:0] S_RELQ = 2'd3;

    localparam logic [7:0] KEY_NONE  = 8'h00;
    localparam logic [7:0] KEY_PAUSE = 8'h13;
    localparam logic [7:0] KEY_MENU  = 8'h10;

    if (STABLE_CYCLES < 2 || STABLE_CYCLES > 65535) begin : g_bad_stable
        $error("key_event_filter: STABLE_CYCLES must be in 2..65535");
    end
    if (REPEAT_CYCLES < 2) begin : g_bad_repeat
        $error("key_event_filter: REPEAT_CYCLES must be at least 2");
    end

    logic [7:0]       raw_q;
    logic [7:0]       cand_q,     cand_d;
    logic [CNT_W-1:0] cnt_q,      cnt_d;
    logic [7:0]       level_q,    level_d;
    logic             evt_q,      evt_d;
    logic [7:0]       evt_code_q, evt_code_d;
    logic [1:0]       state_q,    state_d;

    logic stable;
    logic qualify;
    logic new_press;
    logic rep_fire;

    // A candidate qualifies once it has been seen unchanged for STABLE_CYCLES
    // compares and differs from what is already accepted.
    assign stable  = (raw_q == cand_q);
    assign qualify = stable && (cnt_q == CNT_MAX) && (cand_q != level_q);

    // NOTE: every combinational output gets a default first so no latch is inferred.
    always_comb begin
        cand_d = cand_q;
        cnt_d  = cnt_q;
        if (!stable) begin
            cand_d = raw_q;
            cnt_d  = '0;
        end else if (cnt_q != CNT_MAX) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    assign level_d = qualify ? cand_q : level_q;

    always_comb begin
        state_d   = state_q;
        new_press = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (raw_q != KEY_NONE) state_d = S_QUAL;
            end
            S_QUAL: begin
                if (qualify) begin
                    state_d   = S_HELD;
                    new_press = 1'b1;
                end else if (raw_q == KEY_NONE) begin
                    state_d = S_IDLE;
                end
            end
            S_HELD: begin
                if (raw_q != level_q) state_d = S_RELQ;
            end
            S_RELQ: begin
                // A qualifying zero is a release; any other qualifying code is a new press.
                if (qualify) begin
                    if (cand_q == KEY_NONE) begin
                        state_d = S_IDLE;
                    end else begin
                        state_d   = S_HELD;
                        new_press = 1'b1;
                    end
                end else if (raw_q == level_q) begin
                    state_d = S_HELD;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

`ifdef KEY_EVENT_FILTER_REPEAT_EN
    localparam int unsigned      REP_W   = (REPEAT_CYCLES > 2) ? $clog2(REPEAT_CYCLES) : 1;
    localparam logic [REP_W-1:0] REP_MAX = REP_W'(REPEAT_CYCLES - 1);

    logic [REP_W-1:0] rep_q, rep_d;

    // The repeat timer only runs while the key stays in HELD; any exit clears it.
    always_comb begin
        rep_d    = '0;
        rep_fire = 1'b0;
        if (state_q == S_HELD && state_d == S_HELD) begin
            if (rep_q == REP_MAX) begin
                rep_fire = (level_q != KEY_PAUSE) && (level_q != KEY_MENU);
            end else begin
                rep_d = rep_q + REP_W'(1);
            end
        end
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            rep_q <= '0;
        end else begin
            rep_q <= rep_d;
        end
    end
`else
    assign rep_fire = 1'b0;
`endif

    assign evt_d      = new_press || rep_fire;
    assign evt_code_d = evt_d ? level_d : KEY_NONE;

    // NOTE: state registers use non-blocking assignments so every flop samples
    // pre-edge values; the reset branch comes first so it overrides all updates.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            raw_q      <= '0;
            cand_q     <= '0;
            cnt_q      <= '0;
            level_q    <= '0;
            evt_q      <= 1'b0;
            evt_code_q <= '0;
            state_q    <= S_IDLE;
        end else begin
            raw_q      <= keycode_raw;
            cand_q     <= cand_d;
            cnt_q      <= cnt_d;
            level_q    <= level_d;
            evt_q      <= evt_d;
            evt_code_q <= evt_code_d;
            state_q    <= state_d;
        end
    end

    assign key_level    = level_q;
    assign key_evt      = evt_q;
    assign key_evt_code = evt_code_q;

endmodule

// File: tb/tb_key_event_filter.sv
// Randomised scoreboard bench for key_event_filter: a run-length reference model
// predicts level and press events per edge; a monitor compares them against the DUT.
module tb_key_event_filter;

    localparam int S = 4;
    localparam int R = 8;
`ifdef KEY_EVENT_FILTER_REPEAT_EN
    localparam bit REPEAT_ON = 1'b1;
`else
    localparam bit REPEAT_ON = 1'b0;
`endif

    logic       Clk = 1'b0;
    logic       Reset;
    logic [7:0] keycode_raw;
    logic [7:0] key_level;
    logic       key_evt;
    logic [7:0] key_evt_code;

    key_event_filter #(
        .STABLE_CYCLES(S),
        .REPEAT_CYCLES(R)
    ) dut (
        .Clk         (Clk),
        .Reset       (Reset),
        .keycode_raw (keycode_raw),
        .key_level   (key_level),
        .key_evt     (key_evt),
        .key_evt_code(key_evt_code)
    );

    always #5 Clk = ~Clk;

    typedef struct {
        int         at;
        logic [7:0] code;
    } evt_t;

    evt_t       evt_q[$];
    logic [7:0] lvl_q[$];

    int checks        = 0;
    int failures      = 0;
    int cyc           = 0;
    int evt_seen      = 0;
    int last_evt_edge = 0;

    always @(posedge Clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s at edge %0d: got 0x%0h, expected 0x%0h", name, cyc, act, exp);
        end
    endtask

    // Reference model: a code becomes the level once it has been captured on
    // S+1 consecutive edges and differs from the current level; the change (and
    // the event for a nonzero code) appears on the following edge.
    logic [7:0] m_level;
    logic [7:0] m_run_code;
    int         m_run_len;
    bit         m_run_valid;
    bit         m_pend;
    logic [7:0] m_pend_code;
    int         m_pend_at;
    bit         m_anchor_ok;
    int         m_anchor;

    task automatic model_step(input logic [7:0] code, input logic rst, input int e);
        if (rst) begin
            m_level     = 8'h00;
            m_run_valid = 1'b0;
            m_run_len   = 0;
            m_pend      = 1'b0;
            m_anchor_ok = 1'b0;
        end else begin
            if (m_pend && m_pend_at == e) begin
                m_pend  = 1'b0;
                m_level = m_pend_code;
                if (m_level != 8'h00) begin
                    evt_q.push_back('{e, m_level});
                    m_anchor_ok = 1'b1;
                    m_anchor    = e;
                end else begin
                    m_anchor_ok = 1'b0;
                end
            end else if (REPEAT_ON && m_anchor_ok && m_level != 8'h13 && m_level != 8'h10
                         && e > m_anchor && ((e - m_anchor) % R) == 0) begin
                evt_q.push_back('{e, m_level});
            end
            if (m_run_valid && code == m_run_code) begin
                m_run_len++;
            end else begin
                m_run_code  = code;
                m_run_len   = 1;
                m_run_valid = 1'b1;
            end
            // Holding a key restarts its repeat period after any deviation.
            if (code != m_level) begin
                m_anchor_ok = 1'b0;
            end else if (!m_anchor_ok && m_level != 8'h00) begin
                m_anchor_ok = 1'b1;
                m_anchor    = e + 1;
            end
            if (m_run_len == S + 1 && m_run_code != m_level) begin
                m_pend      = 1'b1;
                m_pend_code = m_run_code;
                m_pend_at   = e + 1;
            end
        end
        lvl_q.push_back(m_level);
    endtask

    task automatic drive(input logic [7:0] code, input logic rst);
        int e;
        e           = cyc + 1;
        keycode_raw = code;
        Reset       = rst;
        model_step(code, rst, e);
        @(negedge Clk);
    endtask

    task automatic hold(input logic [7:0] code, input int n);
        for (int i = 0; i < n; i++) drive(code, 1'b0);
    endtask

    initial begin : monitor
        evt_t       exp_e;
        logic [7:0] exp_lvl;
        forever begin
            @(posedge Clk);
            #1;
            if (lvl_q.size() > 0) begin
                exp_lvl = lvl_q.pop_front();
                check("key_level", 32'(key_level), 32'(exp_lvl));
            end
            if (key_evt === 1'b1) begin
                evt_seen++;
                last_evt_edge = cyc;
            end
            if (evt_q.size() > 0 && evt_q[0].at == cyc) begin
                exp_e = evt_q.pop_front();
                check("key_evt", 32'(key_evt), 32'd1);
                check("key_evt_code", 32'(key_evt_code), 32'(exp_e.code));
            end else begin
                check("key_evt", 32'(key_evt), 32'd0);
                check("key_evt_code", 32'(key_evt_code), 32'd0);
            end
        end
    end

    initial begin : main
        int         base;
        int         cap;
        int         idx;
        int         len;
        logic [7:0] code;

        keycode_raw = 8'h00;
        Reset       = 1'b1;
        repeat (3) drive(8'h00, 1'b1);
        hold(8'h00, 4);
        check("reset_level", 32'(key_level), 32'd0);

        // Basic press and release.
        base = evt_seen;
        cap  = cyc + 1;
        hold(8'h13, 20);
        hold(8'h00, 10);
        check("press_count", 32'(evt_seen - base), 32'd1);
        check("press_latency", 32'(last_evt_edge - cap), 32'(S + 1));
        check("release_level", 32'(key_level), 32'd0);

        // Glitch shorter than the stability window.
        base = evt_seen;
        hold(8'h2C, 3);
        hold(8'h00, 10);
        check("glitch_count", 32'(evt_seen - base), 32'd0);
        check("glitch_level", 32'(key_level), 32'd0);

        // Direct code-to-code change.
        base = evt_seen;
        hold(8'h13, 10);
        hold(8'h10, 10);
        check("direct_change_level", 32'(key_level), 32'h10);
        hold(8'h00, 10);
        check("direct_change_count", 32'(evt_seen - base), 32'd2);

        // Reset while a qualification is two counts in.
        hold(8'h1A, 4);
        drive(8'h1A, 1'b1);
        check("reset_mid_level", 32'(key_level), 32'd0);
        check("reset_mid_evt", 32'(key_evt), 32'd0);
        base = evt_seen;
        cap  = cyc + 1;
        hold(8'h1A, 10);
        hold(8'h00, 10);
        check("reset_mid_count", 32'(evt_seen - base), 32'd1);
        check("reset_mid_latency", 32'(last_evt_edge - cap), 32'(S + 1));

        // Long holds: repeating code and a non-repeating pause code.
        base = evt_seen;
        hold(8'h1A, 40);
        check("long_hold_count", 32'(evt_seen - base), REPEAT_ON ? 32'd5 : 32'd1);
        hold(8'h00, 10);
        base = evt_seen;
        hold(8'h13, 40);
        hold(8'h00, 10);
        check("pause_hold_count", 32'(evt_seen - base), 32'd1);

        // Random segments with occasional single-cycle resets.
        for (int seg = 0; seg < 150; seg++) begin
            idx = $urandom_range(0, 5);
            case (idx)
                0:       code = 8'h00;
                1:       code = 8'h13;
                2:       code = 8'h10;
                3:       code = 8'h2C;
                4:       code = 8'h1A;
                default: code = 8'($urandom_range(1, 255));
            endcase
            len = $urandom_range(1, 2 * S + 6);
            for (int i = 0; i < len; i++) drive(code, ($urandom_range(0, 199) == 0));
        end
        hold(8'h00, 2 * S + 4);
        check("evt_queue_drained", 32'(evt_q.size()), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
